// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit: funct3 codes, FSM states,
// byte-enable / store-lane helpers and the access legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_t;

  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] addr);
    logic [3:0] be;
    case (funct3)
      F3_B, F3_BU: be = 4'b0001 << addr;
      F3_H, F3_HU: be = addr[1] ? 4'b1100 : 4'b0011;
      default:     be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [2:0] funct3, input logic [31:0] data);
    logic [31:0] rep;
    case (funct3)
      F3_B:    rep = {4{data[7:0]}};
      F3_H:    rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

  // Alignment, funct3 encoding and read/write exclusivity all fold into one verdict.
  function automatic logic access_legal(input logic [2:0] funct3, input logic [1:0] addr,
                                        input logic is_rd, input logic is_wr);
    logic ok;
    case (funct3)
      F3_B, F3_BU: ok = 1'b1;
      F3_H, F3_HU: ok = ~addr[0];
      F3_W:        ok = (addr == 2'b00);
      default:     ok = 1'b0;
    endcase
    if (is_wr && funct3[2]) ok = 1'b0;
    if (is_rd && is_wr)     ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load-data extraction: selects the addressed byte/halfword lane from the
// bus word and sign- or zero-extends it according to funct3.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    data_o = '0;
    lane   = rdata_i >> {addr_lo_i, 3'b000};
    case (funct3_i)
      F3_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      F3_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      F3_W:    data_o = lane;
      F3_BU:   data_o = {24'b0, lane[7:0]};
      F3_HU:   data_o = {16'b0, lane[15:0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: turns a decoded core memory op into a word-aligned req/gnt/rvalid
// bus transaction, stalls the core until it completes and returns extended load data.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  DATAMEMControl,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        MisalignFault,
  output logic        BusError,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t    state_q, state_d;
  logic [2:0]    f3_q, f3_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          we_q, we_d;
  logic          fault_q, fault_d;
  logic          buserr_q, buserr_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   load_data;
  logic          legal;
  logic          in_req, in_flight, resp;

  dmem_load_align u_align (
    .rdata_i   (mem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .data_o    (load_data)
  );

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    fault_d  = fault_q;
    buserr_d = buserr_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    legal    = access_legal(DATAMEMControl, Addr[1:0], MemRead, MemWrite);
    unique case (state_q)
      IDLE: begin
        if (MemRead || MemWrite) begin
          f3_d     = DATAMEMControl;
          addr_d   = Addr;
          wdata_d  = WriteData;
          we_d     = MemWrite;
          fault_d  = ~legal;
          buserr_d = 1'b0;
          rdata_d  = '0;
          cnt_d    = '0;
          state_d  = legal ? REQ : RESP;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt && we_q) begin
          state_d = RESP;
        end else if (mem_gnt && mem_rvalid) begin
          rdata_d = load_data;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          buserr_d = 1'b1;
          state_d  = RESP;
        end else if (mem_gnt) begin
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          rdata_d = load_data;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          buserr_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      fault_q  <= 1'b0;
      buserr_q <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      fault_q  <= fault_d;
      buserr_q <= buserr_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_req    = (state_q == REQ);
  assign in_flight = in_req || (state_q == WAIT_R);
  assign resp      = (state_q == RESP);

  // Bus outputs are qualified by REQ so they idle at zero outside a live request.
  assign mem_req   = in_req;
  assign mem_we    = in_req & we_q;
  assign mem_addr  = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_be    = in_req ? be_gen(f3_q, addr_q[1:0]) : '0;
  assign mem_wdata = (in_req && we_q) ? wdata_rep(f3_q, wdata_q) : '0;

  assign Done          = resp;
  assign MisalignFault = resp & fault_q;
  assign BusError      = resp & buserr_q;
  assign ReadData      = resp ? rdata_q : '0;

  // Reset gates the request term so a core still holding MemRead sees the stall release at once.
  assign Stall = ~rst & (((state_q == IDLE) & (MemRead | MemWrite)) | in_flight);

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: expected responses are queued at request time and
// popped when Done appears; bus-side fields are checked cycle by cycle.
module tb_dmem_lsu;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemRead, MemWrite;
  logic [2:0]  DATAMEMControl;
  logic [31:0] Addr, WriteData, ReadData;
  logic        Stall, Done, MisalignFault, BusError;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;

  always #5 clk = ~clk;

  dmem_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .DATAMEMControl (DATAMEMControl),
    .Addr           (Addr),
    .WriteData      (WriteData),
    .ReadData       (ReadData),
    .Stall          (Stall),
    .Done           (Done),
    .MisalignFault  (MisalignFault),
    .BusError       (BusError),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_be         (mem_be),
    .mem_wdata      (mem_wdata),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        misalign;
    logic        buserr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Moves to 1 time unit after the next rising edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input logic [31:0] rd, input logic mf, input logic be);
    exp_t e;
    e.rdata    = rd;
    e.misalign = mf;
    e.buserr   = be;
    exp_q.push_back(e);
  endtask

  // Called at a check point; Done must be high now. Pops and compares the response.
  task automatic check_done(input string tag);
    exp_t e;
    chk({tag, "_done"}, Done, 1'b1);
    chk({tag, "_stall_resp"}, Stall, 1'b0);
    chk({tag, "_sb_pending"}, exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, ReadData, e.rdata);
      chk({tag, "_misalign"}, MisalignFault, e.misalign);
      chk({tag, "_buserr"}, BusError, e.buserr);
    end
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] word, input logic [31:0] exp_rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_addr,
                         input bit same_cycle);
    tick();
    MemRead = 1'b1; DATAMEMControl = f3; Addr = addr; WriteData = 32'h5A5A_5A5A;
    sb_push(exp_rd, 1'b0, 1'b0);
    #1;
    chk({tag, "_stall_idle"}, Stall, 1'b1);
    tick();
    mem_gnt = 1'b1; mem_rvalid = same_cycle; mem_rdata = word;
    #1;
    chk({tag, "_req"}, mem_req, 1'b1);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_addr"}, mem_addr, exp_addr);
    chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
    chk({tag, "_wdata"}, mem_wdata, 32'h0);
    if (!same_cycle) begin
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1;
      #1;
      chk({tag, "_wait_done"}, Done, 1'b0);
      chk({tag, "_wait_req"}, mem_req, 1'b0);
      chk({tag, "_wait_stall"}, Stall, 1'b1);
    end
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    #1;
    check_done(tag);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_be,
                          input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                          input int gnt_wait);
    tick();
    MemWrite = 1'b1; DATAMEMControl = f3; Addr = addr; WriteData = wd;
    sb_push(32'h0, 1'b0, 1'b0);
    #1;
    chk({tag, "_stall_idle"}, Stall, 1'b1);
    chk({tag, "_noreq_idle"}, mem_req, 1'b0);
    for (int i = 0; i <= gnt_wait; i++) begin
      tick();
      mem_gnt = (i == gnt_wait);
      #1;
      chk({tag, "_req"}, mem_req, 1'b1);
      chk({tag, "_we"}, mem_we, 1'b1);
      chk({tag, "_addr"}, mem_addr, exp_addr);
      chk({tag, "_be"}, {28'b0, mem_be}, {28'b0, exp_be});
      chk({tag, "_wdata"}, mem_wdata, exp_wdata);
      chk({tag, "_stall"}, Stall, 1'b1);
    end
    tick();
    mem_gnt = 1'b0;
    #1;
    check_done(tag);
  endtask

  task automatic do_fault(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr);
    tick();
    MemRead = rd; MemWrite = wr; DATAMEMControl = f3; Addr = addr; WriteData = 32'hCAFE_0001;
    sb_push(32'h0, 1'b1, 1'b0);
    #1;
    chk({tag, "_stall_idle"}, Stall, 1'b1);
    tick();
    #1;
    chk({tag, "_noreq"}, mem_req, 1'b0);
    check_done(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b0; DATAMEMControl = 3'b0; Addr = '0; WriteData = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2;
    chk("rst_stall", Stall, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_be", {28'b0, mem_be}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_rdata", ReadData, 32'h0);
    chk("rst_flags", {30'b0, MisalignFault, BusError}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    do_store("sw", F3_W, 32'h100, 32'hDEADBEEF, 4'b1111, 32'h100, 32'hDEADBEEF, 0);
    do_store("sh", F3_H, 32'h0A, 32'h1234ABCD, 4'b1100, 32'h08, 32'hABCDABCD, 0);
    do_store("sb_wait", F3_B, 32'h101, 32'h00000077, 4'b0010, 32'h100, 32'h77777777, 2);

    do_load("lb", F3_B, 32'h103, 32'h80123456, 32'hFFFFFF80, 4'b1000, 32'h100, 1'b0);
    do_load("lbu", F3_BU, 32'h103, 32'h80123456, 32'h00000080, 4'b1000, 32'h100, 1'b0);
    do_load("lhu", F3_HU, 32'h102, 32'h80123456, 32'h00008012, 4'b1100, 32'h100, 1'b0);
    do_load("lh", F3_H, 32'h102, 32'h80123456, 32'hFFFF8012, 4'b1100, 32'h100, 1'b0);
    do_load("lh_pos", F3_H, 32'h200, 32'h00007FFF, 32'h00007FFF, 4'b0011, 32'h200, 1'b0);
    do_load("lw_fast", F3_W, 32'h104, 32'hCAFEF00D, 32'hCAFEF00D, 4'b1111, 32'h104, 1'b1);
    do_load("lb_lane1", F3_B, 32'h301, 32'h00008000, 32'hFFFFFF80, 4'b0010, 32'h300, 1'b1);

    do_fault("lw_mis", 1'b1, 1'b0, F3_W, 32'h102);
    do_fault("f3_011", 1'b1, 1'b0, 3'b011, 32'h100);
    do_fault("lh_odd", 1'b1, 1'b0, F3_HU, 32'h101);
    do_fault("sbu_st", 1'b0, 1'b1, F3_BU, 32'h100);
    do_fault("rd_wr", 1'b1, 1'b1, F3_W, 32'h100);

    // Timeout: grant on the third REQ cycle, rvalid never arrives.
    tick();
    MemRead = 1'b1; DATAMEMControl = F3_W; Addr = 32'h200;
    sb_push(32'h0, 1'b0, 1'b1);
    #1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      mem_gnt = (i == 3);
      #1;
      chk("to_req_held", mem_req, 1'b1);
    end
    for (int i = 4; i <= 8; i++) begin
      tick();
      mem_gnt = 1'b0;
      #1;
      chk("to_wait_req", mem_req, 1'b0);
      chk("to_wait_done", Done, 1'b0);
      chk("to_wait_stall", Stall, 1'b1);
    end
    tick();
    #1;
    check_done("timeout");

    // Reset asserted while in REQ: request must vanish immediately.
    tick();
    MemRead = 1'b1; DATAMEMControl = F3_W; Addr = 32'h400;
    tick();
    #1;
    chk("rreq_req_before", mem_req, 1'b1);
    rst = 1'b1;
    #1;
    chk("rreq_req", mem_req, 1'b0);
    chk("rreq_stall", Stall, 1'b0);
    MemRead = 1'b0;
    tick();
    rst = 1'b0;

    // Reset asserted while in WAIT_R, then a stray rvalid.
    tick();
    MemRead = 1'b1; DATAMEMControl = F3_W; Addr = 32'h300;
    tick();
    mem_gnt = 1'b1;
    #1;
    chk("rwait_req", mem_req, 1'b1);
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("rwait_stall_before", Stall, 1'b1);
    rst = 1'b1;
    #1;
    chk("rwait_stall", Stall, 1'b0);
    chk("rwait_req_rst", mem_req, 1'b0);
    chk("rwait_done_rst", Done, 1'b0);
    MemRead = 1'b0;
    tick();
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk("stray_done", Done, 1'b0);
      chk("stray_rdata", ReadData, 32'h0);
    end
    mem_rvalid = 1'b0;

    chk("sb_drained", exp_q.size() == 0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
